// File: rtl/fifo_stream_reader.sv
// Read-side drain stage for the synchronous FIFO: issues reads against a credit limit and
// re-presents captured words on a valid/ready stream. Optional counter: FIFO_RD_WORD_CNT_EN.
module fifo_stream_reader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SKID_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [1:0]            occupancy
`ifdef FIFO_RD_WORD_CNT_EN
  ,
  input  logic                  cnt_clear,
  output logic [31:0]           word_count
`endif
);

  if (SKID_DEPTH != 2) begin : g_bad_depth
    $error("fifo_stream_reader: SKID_DEPTH must be 2");
  end

  logic [DATA_WIDTH-1:0] skid_q [2];
  logic                  head_q;
  logic                  tail_q;
  logic [1:0]            occ_q;
  logic                  inflight_q;
  logic                  pop;
  logic [2:0]            committed;

  assign m_valid   = (occ_q != 2'd0);
  assign m_data    = skid_q[head_q];
  assign occupancy = occ_q;

  // Credit check: buffered plus outstanding words, less the one leaving now, must leave a slot.
  always_comb begin
    pop        = m_valid && m_ready;
    committed  = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    fifo_rd_en = enable && !fifo_empty && !reset && (committed < 3'd2);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        skid_q[i] <= '0;
      end
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= fifo_rd_en;
      if (inflight_q) begin
        skid_q[tail_q] <= fifo_data;
        tail_q         <= ~tail_q;
      end
      if (pop) begin
        head_q <= ~head_q;
      end
      case ({inflight_q, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

`ifdef FIFO_RD_WORD_CNT_EN
  logic [31:0] word_count_q;

  assign word_count = word_count_q;

  // Clear has priority over a coincident pop.
  always_ff @(posedge clk) begin
    if (reset || cnt_clear) begin
      word_count_q <= 32'd0;
    end else if (pop) begin
      word_count_q <= word_count_q + 32'd1;
    end
  end
`endif

endmodule
